spi_host_master: RTL and testbench

- SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first) that drives the motor controller's SPI slave interface (sclk, ss, mosi, miso).
- Used on the host/test side to issue command words and read status words from the motor controller.
- Single-word transactions, or back-to-back words under one chip-select.
- Handshake on the local side is start/busy/done.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_host_master_if.sv | 31 +++
 rtl/spi_half_tick.sv | 33 +++
 rtl/spi_host_master.sv | 139 +++++++++++++
 tb/tb_spi_host_master.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the host-side master and the slave side.
// Contents:
//   spi_state_t      - master sequencing states
//   SPI_CPOL/SPI_CPHA - bus mode constants (mode 0: sclk idles low, data
//                       sampled on the rising edge, shifted on the falling edge)
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,   // ss high, waiting for start
        ST_SEL,    // ss held low between kept words, waiting for start
        ST_SETUP,  // first half-period: MSB on mosi before the first rise
        ST_HIGH,   // sclk high half-period
        ST_LOW,    // sclk low half-period between bits
        ST_HOLD,   // ss hold time after the last fall
        ST_GAP     // ss high recovery time before returning to IDLE
    } spi_state_t;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_host_master_if.sv
// Local start/busy/done handshake of the SPI host master.
// Signals:
//   start   - request one word transfer
//   keep    - keep ss asserted after this word (sampled with start)
//   tx_data - word to send (captured when start is accepted)
//   rx_data - last received word, held until the next done
//   busy    - transfer sequence in progress
//   done    - one-cycle pulse when the last bit has completed
// Modports:
//   master - the requester driving start/keep/tx_data
//   slave  - the SPI host master block answering the requests
interface spi_host_master_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             keep;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic             done;

    modport master (
        output start, keep, tx_data,
        input  rx_data, busy, done
    );

    modport slave (
        input  start, keep, tx_data,
        output rx_data, busy, done
    );
endinterface

// File: rtl/spi_half_tick.sv
// Half-period down-counter for the SPI master.
// Ports:
//   clk    - system clock
//   rstn   - synchronous active-low reset
//   reload - load DIV-1 (asserted on the edge that enters a new state)
//   tick   - high while the count is 0, i.e. the last cycle of a phase
// After a reload the counter shows DIV-1 in the first cycle of the new
// state, so tick appears exactly DIV cycles later. Without a reload it
// parks at 0 and tick stays high.
module spi_half_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic reload,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (reload) begin
            cnt_reg <= CW'(DIV - 1);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign tick = (cnt_reg == '0);
endmodule

// File: rtl/spi_host_master.sv
// SPI host master, mode 0, MSB first, one word per start, optional
// back-to-back words under a single chip select.
// Parameters:
//   WIDTH - bits per word (2..32)
//   DIV   - system clocks per sclk half-period (>= 2)
// Ports:
//   clk, rstn            - system clock, synchronous active-low reset
//   ctrl (slave modport) - start/keep/tx_data in, rx_data/busy/done out
//   sclk, ss, mosi       - SPI outputs (sclk idles low, ss idles high)
//   miso                 - SPI input; no synchroniser since the slave only
//                          changes it on sclk falls generated here
module spi_host_master
    import spi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    spi_host_master_if.slave ctrl,
    output logic             sclk,
    output logic             ss,
    output logic             mosi,
    input  logic             miso
);
    // Must hold WIDTH itself without wrapping when WIDTH is a power of two.
    localparam int BW = $clog2(WIDTH + 1);

    if (DIV < 2) begin : g_bad_div
        $error("spi_host_master: DIV must be >= 2");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("spi_host_master: WIDTH must be in 2..32");
    end
    if (SPI_CPHA != 1'b0) begin : g_bad_mode
        $error("spi_host_master: only CPHA=0 is implemented");
    end

    spi_state_t       state_reg;
    logic [WIDTH-1:0] tx_shift_reg;
    logic [WIDTH-1:0] rx_shift_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic             keep_reg;
    logic             reload;
    logic             tick;

    spi_half_tick #(.DIV(DIV)) u_half_tick (
        .clk    (clk),
        .rstn   (rstn),
        .reload (reload),
        .tick   (tick)
    );

    // The counter must reload on exactly the edges where the state changes.
    always_comb begin
        reload = 1'b0;
        case (state_reg)
            ST_IDLE: reload = ctrl.start;
            ST_SEL:  reload = ctrl.start | ~ctrl.keep;
            default: reload = tick;
        endcase
    end

    // mosi is the top of the transmit shifter: loaded on accept, shifted
    // only on sclk falls, so it never moves during the high phase.
    assign mosi = tx_shift_reg[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
            keep_reg     <= 1'b0;
            sclk         <= SPI_CPOL;
            ss           <= 1'b1;
            ctrl.busy    <= 1'b0;
            ctrl.done    <= 1'b0;
            ctrl.rx_data <= '0;
        end else begin
            ctrl.done <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_SEL: begin
                    if (ctrl.start) begin
                        tx_shift_reg <= ctrl.tx_data;
                        keep_reg     <= ctrl.keep;
                        bit_cnt_reg  <= '0;
                        ss           <= 1'b0;
                        ctrl.busy    <= 1'b1;
                        state_reg    <= ST_SETUP;
                    end else if (state_reg == ST_SEL && !ctrl.keep) begin
                        // Release without a word; busy stays low throughout.
                        ss        <= 1'b1;
                        state_reg <= ST_GAP;
                    end
                end
                ST_SETUP, ST_LOW: begin
                    if (tick) begin
                        sclk         <= ~SPI_CPOL;
                        rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], miso};
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        state_reg    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        sclk <= SPI_CPOL;
                        if (bit_cnt_reg == BW'(WIDTH)) begin
                            ctrl.done    <= 1'b1;
                            ctrl.rx_data <= rx_shift_reg;
                            state_reg    <= ST_HOLD;
                        end else begin
                            tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
                            state_reg    <= ST_LOW;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (keep_reg) begin
                            ctrl.busy <= 1'b0;
                            state_reg <= ST_SEL;
                        end else begin
                            ss        <= 1'b1;
                            state_reg <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        ctrl.busy <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: one WIDTH=8/DIV=2 instance against a mode-0
// slave model with scripted responses, plus WIDTH=2/DIV=2 and
// WIDTH=32/DIV=3 instances in mosi->miso loopback.
module tb_spi_host_master;
    localparam int M_DIV  = 2;
    localparam int T_DONE = 1 + 2 * M_DIV * 8;
    localparam int A_DIV  = 2;
    localparam int B_DIV  = 3;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   failures;

    spi_host_master_if #(.WIDTH(8))  m_if ();
    spi_host_master_if #(.WIDTH(2))  a_if ();
    spi_host_master_if #(.WIDTH(32)) b_if ();

    logic sclk_m, ss_m, mosi_m, miso_m;
    logic sclk_a, ss_a, mosi_a;
    logic sclk_b, ss_b, mosi_b;

    spi_host_master #(.WIDTH(8), .DIV(M_DIV)) dut_m (
        .clk(clk), .rstn(rstn), .ctrl(m_if),
        .sclk(sclk_m), .ss(ss_m), .mosi(mosi_m), .miso(miso_m)
    );
    spi_host_master #(.WIDTH(2), .DIV(A_DIV)) dut_a (
        .clk(clk), .rstn(rstn), .ctrl(a_if),
        .sclk(sclk_a), .ss(ss_a), .mosi(mosi_a), .miso(mosi_a)
    );
    spi_host_master #(.WIDTH(32), .DIV(B_DIV)) dut_b (
        .clk(clk), .rstn(rstn), .ctrl(b_if),
        .sclk(sclk_b), .ss(ss_b), .mosi(mosi_b), .miso(mosi_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Mode-0 slave model: captures mosi on each sclk rise, a word every 8
    // rises after slave_base; presents response bit (falls since base) on miso.
    int         rises_m, fall_cnt, slave_base, slave_idx;
    logic [7:0] slave_cur, slave_rx;
    logic [7:0] slave_q[$];

    always @(posedge sclk_m) begin
        rises_m  <= rises_m + 1;
        slave_rx <= {slave_rx[6:0], mosi_m};
        if (rises_m + 1 - slave_base == 8) slave_q.push_back({slave_rx[6:0], mosi_m});
    end
    always @(negedge sclk_m) fall_cnt <= rises_m;

    always_comb begin
        slave_idx = fall_cnt - slave_base;
        miso_m = (slave_idx >= 0 && slave_idx < 8) ? slave_cur[3'(7 - slave_idx)] : 1'b0;
    end

    int rises_a, rises_b;
    always @(posedge sclk_a) rises_a <= rises_a + 1;
    always @(posedge sclk_b) rises_b <= rises_b + 1;

    // Bus monitors sampled away from the active edge.
    int   mosi_glitch, ss_rises, dones;
    logic prev_mosi, prev_ss;
    always @(negedge clk) begin
        if (rstn && sclk_m === 1'b1 && mosi_m !== prev_mosi) mosi_glitch <= mosi_glitch + 1;
        if (ss_m === 1'b1 && prev_ss === 1'b0) ss_rises <= ss_rises + 1;
        if (m_if.done === 1'b1) dones <= dones + 1;
        prev_mosi <= mosi_m;
        prev_ss   <= ss_m;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // One word on the main instance; caller is at a negedge with busy=0.
    task automatic xfer(input logic [7:0] tx, input logic k, input logic [7:0] resp,
                        input logic [7:0] exp_rx, input int poke);
        int c0, t, r0;
        logic [7:0] got;
        slave_cur  = resp;
        slave_base = rises_m;
        r0         = rises_m;
        m_if.tx_data = tx;
        m_if.keep    = k;
        m_if.start   = 1'b1;
        c0 = cyc;
        @(negedge clk);
        m_if.start = 1'b0;
        check("ss_low_cycle1", ss_m, 1'b0);
        check("busy_cycle1", m_if.busy, 1'b1);
        check("mosi_msb_cycle1", mosi_m, tx[7]);
        t = 0;
        while (m_if.done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
            if (poke > 0 && cyc - c0 == poke) begin
                m_if.start   = 1'b1;
                m_if.tx_data = ~tx;
            end else begin
                m_if.start = 1'b0;
            end
        end
        m_if.start = 1'b0;
        check("done_cycle", cyc - c0, T_DONE);
        check("rx_data", m_if.rx_data, exp_rx);
        check("sclk_rises", rises_m - r0, 8);
        got = 8'hxx;
        if (slave_q.size() > 0) got = slave_q.pop_front();
        check("slave_got_tx", got, tx);
        t = 0;
        if (!k) begin
            while (ss_m !== 1'b1 && t < 50) begin @(negedge clk); t++; end
            check("ss_rise_cycle", cyc - c0, T_DONE + M_DIV);
        end
        t = 0;
        while (m_if.busy !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        check("busy_fall_cycle", cyc - c0, T_DONE + (k ? M_DIV : 2 * M_DIV));
        if (k) check("ss_held_in_sel", ss_m, 1'b0);
    endtask

    task automatic word_a(input logic [1:0] tx);
        int c0, t, r0;
        r0 = rises_a;
        a_if.tx_data = tx; a_if.keep = 1'b0; a_if.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        a_if.start = 1'b0;
        for (t = 0; t < 100 && a_if.done !== 1'b1; t++) @(negedge clk);
        check("w2_done_cycle", cyc - c0, 1 + 2 * A_DIV * 2);
        check("w2_rx_loopback", a_if.rx_data, tx);
        check("w2_rises", rises_a - r0, 2);
        for (t = 0; t < 100 && a_if.busy !== 1'b0; t++) @(negedge clk);
        check("w2_ss_idle", ss_a, 1'b1);
    endtask

    task automatic word_b(input logic [31:0] tx);
        int c0, t, r0;
        r0 = rises_b;
        b_if.tx_data = tx; b_if.keep = 1'b0; b_if.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        b_if.start = 1'b0;
        for (t = 0; t < 400 && b_if.done !== 1'b1; t++) @(negedge clk);
        check("w32_done_cycle", cyc - c0, 1 + 2 * B_DIV * 32);
        check("w32_rx_loopback", b_if.rx_data, tx);
        check("w32_rises", rises_b - r0, 32);
        for (t = 0; t < 400 && b_if.busy !== 1'b0; t++) @(negedge clk);
        check("w32_ss_idle", ss_b, 1'b1);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       keep;
        logic [7:0] resp;
        logic [7:0] exp_rx;
        int         poke;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int r_ss, d0, r0, t;
        logic [7:0] tx, resp;
        logic       k;

        tbl[0] = '{8'hA5, 1'b0, 8'h3C, 8'h3C, 0};   // single word
        tbl[1] = '{8'h01, 1'b1, 8'hFE, 8'hFE, 0};   // kept pair, first
        tbl[2] = '{8'hFF, 1'b0, 8'h80, 8'h80, 0};   // kept pair, last
        tbl[3] = '{8'h5A, 1'b0, 8'hC3, 8'hC3, 10};  // start while busy
        tbl[4] = '{8'h80, 1'b1, 8'h01, 8'h01, 0};   // leaves ss low for deselect

        checks = 0; failures = 0;
        slave_cur = 8'h00; slave_base = 0;
        rstn = 1'b0;
        m_if.start = 1'b0; m_if.keep = 1'b0; m_if.tx_data = '0;
        a_if.start = 1'b0; a_if.keep = 1'b0; a_if.tx_data = '0;
        b_if.start = 1'b0; b_if.keep = 1'b0; b_if.tx_data = '0;
        repeat (3) @(negedge clk);

        check("rst_ss", ss_m, 1'b1);
        check("rst_sclk", sclk_m, 1'b0);
        check("rst_mosi", mosi_m, 1'b0);
        check("rst_busy", m_if.busy, 1'b0);
        check("rst_done", m_if.done, 1'b0);
        check("rst_rx", m_if.rx_data, 8'h00);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        r_ss = ss_rises;
        for (int i = 0; i < 5; i++)
            xfer(tbl[i].tx, tbl[i].keep, tbl[i].resp, tbl[i].exp_rx, tbl[i].poke);
        check("ss_rises_table", ss_rises - r_ss, 3);

        // Deselect from SEL without a word.
        m_if.keep = 1'b0;
        @(negedge clk);
        check("desel_ss_high", ss_m, 1'b1);
        check("desel_busy_low", m_if.busy, 1'b0);
        repeat (M_DIV + 1) @(negedge clk);
        check("desel_ss_idle", ss_m, 1'b1);
        xfer(8'h3C, 1'b0, 8'hA5, 8'hA5, 0);

        // Randomized words against the slave model.
        for (int i = 0; i < 16; i++) begin
            tx   = 8'($urandom);
            resp = 8'($urandom);
            k    = (i == 15) ? 1'b0 : 1'($urandom_range(0, 1));
            xfer(tx, k, resp, resp, 0);
        end

        // Reset at the third sclk rise.
        d0 = dones;
        slave_cur = 8'h55; slave_base = rises_m; r0 = rises_m;
        m_if.tx_data = 8'hC3; m_if.keep = 1'b0; m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        for (t = 0; t < 100 && rises_m - r0 < 3; t++) @(negedge clk);
        check("midrst_third_rise", rises_m - r0, 3);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_ss", ss_m, 1'b1);
        check("midrst_sclk", sclk_m, 1'b0);
        check("midrst_busy", m_if.busy, 1'b0);
        check("midrst_mosi", mosi_m, 1'b0);
        check("midrst_rx", m_if.rx_data, 8'h00);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", dones - d0, 0);
        check("midrst_idle_ss", ss_m, 1'b1);
        xfer(8'h96, 1'b0, 8'h69, 8'h69, 0);

        // Edge parameters in loopback.
        for (int v = 0; v < 4; v++) word_a(2'(v));
        word_b(32'h8000_0001);
        word_b(32'hFFFF_FFFF);
        word_b($urandom);

        check("mosi_stable_high", mosi_glitch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
